// File: rtl/prim_stack_if.sv
// Command/status bundle for prim_stack.
// No valid/ready: i_op is consumed on every rising edge, with 0 meaning NOP.
interface prim_stack_if #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 4
);
  logic [3:0]            i_op;
  logic [WIDTH-1:0]      i_dat;
  logic                  i_err_clr;
  logic [WIDTH-1:0]      o_t;
  logic [WIDTH-1:0]      o_n;
  logic [WIDTH-1:0]      o_third;
  logic [DEPTH_LOG2+1:0] o_depth;
  logic                  o_empty;
  logic                  o_full;
  logic                  o_ovf;
  logic                  o_unf;

  modport master (
    output i_op, i_dat, i_err_clr,
    input  o_t, o_n, o_third, o_depth, o_empty, o_full, o_ovf, o_unf
  );

  modport slave (
    input  i_op, i_dat, i_err_clr,
    output o_t, o_n, o_third, o_depth, o_empty, o_full, o_ovf, o_unf
  );
endinterface

// File: rtl/prim_stack.sv
// Hardware stack: T and N held in registers, deeper entries in a spill array.
// One op per cycle; precondition violations suppress the op and set sticky flags.
module prim_stack #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input logic        i_clk,
  input logic        i_reset,
  prim_stack_if.slave bus
);
  localparam int ENTRIES = 2 ** DEPTH_LOG2;
  localparam int DW      = DEPTH_LOG2 + 2;
  localparam logic [DW-1:0] CAP = DW'(ENTRIES + 2);

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_PUSH   = 4'd1,
    OP_POP    = 4'd2,
    OP_SETT   = 4'd3,
    OP_POPSET = 4'd4,
    OP_SWAP   = 4'd5,
    OP_OVER   = 4'd6,
    OP_DUP    = 4'd7,
    OP_ROT    = 4'd8,
    OP_NROT   = 4'd9,
    OP_NIP    = 4'd10,
    OP_CLEAR  = 4'd11
  } op_e;

  op_e                   op;
  logic [WIDTH-1:0]      t_q, n_q, t_d, n_d, third;
  logic [DW-1:0]         depth_q, depth_d, need_min;
  logic                  need_room, unf_hit, ovf_hit, exec;
  logic                  ovf_q, unf_q;
  logic [WIDTH-1:0]      mem [ENTRIES];
  logic [DEPTH_LOG2-1:0] spill_idx, third_idx, wr_idx;
  logic                  wr_en;
  logic [WIDTH-1:0]      wr_data;

  assign op = op_e'(bus.i_op);

  // Array slot k holds stack entry k (0 = bottom); third lives at depth-3.
  assign spill_idx = DEPTH_LOG2'(depth_q - DW'(2));
  assign third_idx = DEPTH_LOG2'(depth_q - DW'(3));
  assign third     = mem[third_idx];

  always_comb begin
    need_min  = '0;
    need_room = 1'b0;
    case (op)
      OP_PUSH:                     need_room = 1'b1;
      OP_POP, OP_SETT:             need_min  = DW'(1);
      OP_POPSET, OP_SWAP, OP_NIP:  need_min  = DW'(2);
      OP_OVER: begin
        need_min  = DW'(2);
        need_room = 1'b1;
      end
      OP_DUP: begin
        need_min  = DW'(1);
        need_room = 1'b1;
      end
      OP_ROT, OP_NROT:             need_min  = DW'(3);
      default: ;
    endcase
    // Underflow takes priority so a double violation only reports unf.
    unf_hit = (depth_q < need_min);
    ovf_hit = need_room && (depth_q == CAP) && !unf_hit;
    exec    = !unf_hit && !ovf_hit;
  end

  always_comb begin
    t_d     = t_q;
    n_d     = n_q;
    depth_d = depth_q;
    wr_en   = 1'b0;
    wr_idx  = spill_idx;
    wr_data = n_q;
    if (exec) begin
      case (op)
        OP_PUSH: begin
          n_d     = t_q;
          t_d     = bus.i_dat;
          wr_en   = (depth_q >= DW'(2));
          depth_d = depth_q + DW'(1);
        end
        OP_POP: begin
          t_d     = n_q;
          n_d     = third;
          depth_d = depth_q - DW'(1);
        end
        OP_SETT:   t_d = bus.i_dat;
        OP_POPSET: begin
          t_d     = bus.i_dat;
          n_d     = third;
          depth_d = depth_q - DW'(1);
        end
        OP_SWAP: begin
          t_d = n_q;
          n_d = t_q;
        end
        OP_OVER: begin
          t_d     = n_q;
          n_d     = t_q;
          wr_en   = 1'b1;
          depth_d = depth_q + DW'(1);
        end
        OP_DUP: begin
          n_d     = t_q;
          wr_en   = (depth_q >= DW'(2));
          depth_d = depth_q + DW'(1);
        end
        OP_ROT: begin
          t_d    = third;
          n_d    = t_q;
          wr_en  = 1'b1;
          wr_idx = third_idx;
        end
        OP_NROT: begin
          t_d     = n_q;
          n_d     = third;
          wr_en   = 1'b1;
          wr_idx  = third_idx;
          wr_data = t_q;
        end
        OP_NIP: begin
          n_d     = third;
          depth_d = depth_q - DW'(1);
        end
        OP_CLEAR:  depth_d = '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      t_q     <= '0;
      n_q     <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      t_q     <= t_d;
      n_q     <= n_d;
      depth_q <= depth_d;
      ovf_q   <= (ovf_q & ~bus.i_err_clr) | ovf_hit;
      unf_q   <= (unf_q & ~bus.i_err_clr) | unf_hit;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en && !i_reset) mem[wr_idx] <= wr_data;
  end

  assign bus.o_t     = t_q;
  assign bus.o_n     = n_q;
  assign bus.o_third = third;
  assign bus.o_depth = depth_q;
  assign bus.o_empty = (depth_q == '0);
  assign bus.o_full  = (depth_q == CAP);
  assign bus.o_ovf   = ovf_q;
  assign bus.o_unf   = unf_q;
endmodule

// File: tb/tb_prim_stack.sv
// Directed bench for prim_stack at two parameter sets (16/4 with CAP 18, 32/2 with CAP 6).
module tb_prim_stack;
  localparam int W_A = 16, DL_A = 4, CAP_A = 18;
  localparam int W_B = 32, DL_B = 2, CAP_B = 6;

  localparam logic [3:0] NOP = 4'd0, PUSH = 4'd1, POP = 4'd2, SETT = 4'd3,
                         POPSET = 4'd4, SWAP = 4'd5, OVER = 4'd6, DUP = 4'd7,
                         ROT = 4'd8, NROT = 4'd9, NIP = 4'd10, CLEAR = 4'd11;
  localparam logic [2:0] M_ALL = 3'b111, M_TN = 3'b110, M_T = 3'b100, M_NONE = 3'b000;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  prim_stack_if #(.WIDTH(W_A), .DEPTH_LOG2(DL_A)) bus_a ();
  prim_stack_if #(.WIDTH(W_B), .DEPTH_LOG2(DL_B)) bus_b ();

  prim_stack #(.WIDTH(W_A), .DEPTH_LOG2(DL_A)) dut_a (
    .i_clk(clk), .i_reset(rst_a), .bus(bus_a.slave));
  prim_stack #(.WIDTH(W_B), .DEPTH_LOG2(DL_B)) dut_b (
    .i_clk(clk), .i_reset(rst_b), .bus(bus_b.slave));

  // mask selects which of t/n/third are meaningful at the expected depth.
  typedef struct packed {
    logic [2:0]  mask;
    logic [31:0] t;
    logic [31:0] n;
    logic [31:0] third;
    logic [7:0]  depth;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(input logic [2:0] m, input logic [31:0] t, input logic [31:0] n,
                              input logic [31:0] th, input int d, input logic ovf, input logic unf);
    exp_t e;
    e.mask = m; e.t = t; e.n = n; e.third = th;
    e.depth = 8'(d); e.ovf = ovf; e.unf = unf;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare(input string tag, input exp_t e, input logic [31:0] t,
                         input logic [31:0] n, input logic [31:0] th, input logic [7:0] d,
                         input logic ovf, input logic unf, input logic empty, input logic full,
                         input int cap);
    chk({tag, ".depth"}, 32'(d), 32'(e.depth));
    chk({tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
    chk({tag, ".unf"}, 32'(unf), 32'(e.unf));
    chk({tag, ".empty"}, 32'(empty), 32'(e.depth == 8'd0));
    chk({tag, ".full"}, 32'(full), 32'(int'(e.depth) == cap));
    if (e.mask[2]) chk({tag, ".t"}, t, e.t);
    if (e.mask[1]) chk({tag, ".n"}, n, e.n);
    if (e.mask[0]) chk({tag, ".third"}, th, e.third);
  endtask

  task automatic step_a(input string tag, input logic rst, input logic [3:0] op,
                        input logic [31:0] dat, input logic clr, input exp_t e);
    exp_t got;
    exp_q.push_back(e);
    rst_a = rst; bus_a.i_op = op; bus_a.i_dat = W_A'(dat); bus_a.i_err_clr = clr;
    @(posedge clk); #1;
    rst_a = 1'b0; bus_a.i_op = NOP; bus_a.i_err_clr = 1'b0;
    got = exp_q.pop_front();
    compare(tag, got, 32'(bus_a.o_t), 32'(bus_a.o_n), 32'(bus_a.o_third), 8'(bus_a.o_depth),
            bus_a.o_ovf, bus_a.o_unf, bus_a.o_empty, bus_a.o_full, CAP_A);
  endtask

  task automatic step_b(input string tag, input logic rst, input logic [3:0] op,
                        input logic [31:0] dat, input logic clr, input exp_t e);
    exp_t got;
    exp_q.push_back(e);
    rst_b = rst; bus_b.i_op = op; bus_b.i_dat = dat; bus_b.i_err_clr = clr;
    @(posedge clk); #1;
    rst_b = 1'b0; bus_b.i_op = NOP; bus_b.i_err_clr = 1'b0;
    got = exp_q.pop_front();
    compare(tag, got, bus_b.o_t, bus_b.o_n, bus_b.o_third, 8'(bus_b.o_depth),
            bus_b.o_ovf, bus_b.o_unf, bus_b.o_empty, bus_b.o_full, CAP_B);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.i_op = NOP; bus_a.i_dat = '0; bus_a.i_err_clr = 1'b0;
    bus_b.i_op = NOP; bus_b.i_dat = '0; bus_b.i_err_clr = 1'b0;
    @(posedge clk); #1;

    // Reset and basic push
    step_a("a_rst",   1, NOP,  0,        0, mk(M_TN, 0, 0, 0, 0, 0, 0));
    step_a("a_push1", 0, PUSH, 32'h1111, 0, mk(M_T, 32'h1111, 0, 0, 1, 0, 0));
    step_a("a_push2", 0, PUSH, 32'h2222, 0, mk(M_TN, 32'h2222, 32'h1111, 0, 2, 0, 0));
    step_a("a_push3", 0, PUSH, 32'h3333, 0, mk(M_ALL, 32'h3333, 32'h2222, 32'h1111, 3, 0, 0));

    // Shuffles on 1 2 3
    step_a("a_clr0",  0, CLEAR, 0, 0, mk(M_NONE, 0, 0, 0, 0, 0, 0));
    step_a("a_p1",    0, PUSH, 1, 0, mk(M_T, 1, 0, 0, 1, 0, 0));
    step_a("a_p2",    0, PUSH, 2, 0, mk(M_TN, 2, 1, 0, 2, 0, 0));
    step_a("a_p3",    0, PUSH, 3, 0, mk(M_ALL, 3, 2, 1, 3, 0, 0));
    step_a("a_rot",   0, ROT,  0, 0, mk(M_ALL, 1, 3, 2, 3, 0, 0));
    step_a("a_nrot",  0, NROT, 0, 0, mk(M_ALL, 3, 2, 1, 3, 0, 0));
    step_a("a_swap",  0, SWAP, 0, 0, mk(M_ALL, 2, 3, 1, 3, 0, 0));
    step_a("a_over",  0, OVER, 0, 0, mk(M_ALL, 3, 2, 3, 4, 0, 0));
    step_a("a_dup",   0, DUP,  0, 0, mk(M_ALL, 3, 3, 2, 5, 0, 0));
    step_a("a_sett",  0, SETT, 32'h55, 0, mk(M_ALL, 32'h55, 3, 2, 5, 0, 0));
    step_a("a_pop",   0, POP,  0, 0, mk(M_ALL, 3, 2, 3, 4, 0, 0));
    step_a("a_rsvd",  0, 4'd13, 32'hBEEF, 0, mk(M_ALL, 3, 2, 3, 4, 0, 0));

    // Fill to capacity, then overflow attempts
    step_a("a_clr1",  0, CLEAR, 0, 0, mk(M_NONE, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < CAP_A; i++)
      step_a($sformatf("a_fill%0d", i), 0, PUSH, 32'(i), 0,
             mk((i == 0) ? M_T : (i == 1) ? M_TN : M_ALL, 32'(i), 32'(i - 1), 32'(i - 2), i + 1, 0, 0));
    step_a("a_ovf_push", 0, PUSH, 32'hDEAD, 0, mk(M_ALL, 17, 16, 15, 18, 1, 0));
    step_a("a_ovf_dup",  0, DUP,  0, 0, mk(M_ALL, 17, 16, 15, 18, 1, 0));
    step_a("a_ovf_clr",  0, NOP,  0, 1, mk(M_ALL, 17, 16, 15, 18, 0, 0));
    step_a("a_ovf_over", 0, OVER, 0, 0, mk(M_ALL, 17, 16, 15, 18, 1, 0));
    step_a("a_ovf_clr2", 0, NOP,  0, 1, mk(M_ALL, 17, 16, 15, 18, 0, 0));

    // Drain in descending order
    for (int i = 0; i < CAP_A; i++) begin
      int r;
      r = CAP_A - 1 - i;
      step_a($sformatf("a_drain%0d", i), 0, POP, 0, 0,
             mk((r >= 3) ? M_ALL : (r == 2) ? M_TN : (r == 1) ? M_T : M_NONE,
                32'(r - 1), 32'(r - 2), 32'(r - 3), r, 0, 0));
    end

    // Underflow and sticky clear
    step_a("a_unf_pop",  0, POP, 0, 0, mk(M_NONE, 0, 0, 0, 0, 0, 1));
    step_a("a_unf_clr",  0, NOP, 0, 1, mk(M_NONE, 0, 0, 0, 0, 0, 0));
    step_a("a_unf_both", 0, POP, 0, 1, mk(M_NONE, 0, 0, 0, 0, 0, 1));
    step_a("a_unf_clr2", 0, NOP, 0, 1, mk(M_NONE, 0, 0, 0, 0, 0, 0));

    // ALU writeback and NIP underflow
    step_a("a_p5",     0, PUSH,   5, 0, mk(M_T, 5, 0, 0, 1, 0, 0));
    step_a("a_p7",     0, PUSH,   7, 0, mk(M_TN, 7, 5, 0, 2, 0, 0));
    step_a("a_popset", 0, POPSET, 32'h000C, 0, mk(M_T, 32'hC, 0, 0, 1, 0, 0));
    step_a("a_nip_u",  0, NIP,    0, 0, mk(M_T, 32'hC, 0, 0, 1, 0, 1));
    step_a("a_clr3",   0, NOP,    0, 1, mk(M_T, 32'hC, 0, 0, 1, 0, 0));
    step_a("a_over_u", 0, OVER,   0, 0, mk(M_T, 32'hC, 0, 0, 1, 0, 1));
    step_a("a_clr4",   0, NOP,    0, 1, mk(M_T, 32'hC, 0, 0, 1, 0, 0));
    step_a("a_rot_u",  0, ROT,    0, 0, mk(M_T, 32'hC, 0, 0, 1, 0, 1));

    // Reset overriding PUSH at depth 4 with a flag set
    step_a("a_q1", 0, PUSH, 1, 0, mk(M_TN, 1, 32'hC, 0, 2, 0, 1));
    step_a("a_q2", 0, PUSH, 2, 0, mk(M_ALL, 2, 1, 32'hC, 3, 0, 1));
    step_a("a_q3", 0, PUSH, 3, 0, mk(M_ALL, 3, 2, 1, 4, 0, 1));
    step_a("a_rst_push", 1, PUSH, 32'h7777, 0, mk(M_TN, 0, 0, 0, 0, 0, 0));
    step_a("a_sett_u",   0, SETT, 32'h44, 0, mk(M_NONE, 0, 0, 0, 0, 0, 1));
    step_a("a_after",    0, PUSH, 9, 1, mk(M_T, 9, 0, 0, 1, 0, 0));

    // Second configuration: WIDTH 32, CAP 6
    step_b("b_rst", 1, NOP, 0, 0, mk(M_TN, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < CAP_B; i++)
      step_b($sformatf("b_fill%0d", i), 0, PUSH, 32'hA000_0000 + 32'(i), 0,
             mk((i == 0) ? M_T : (i == 1) ? M_TN : M_ALL, 32'hA000_0000 + 32'(i),
                32'hA000_0000 + 32'(i - 1), 32'hA000_0000 + 32'(i - 2), i + 1, 0, 0));
    step_b("b_ovf",  0, PUSH, 32'hDEAD_BEEF, 0,
           mk(M_ALL, 32'hA000_0005, 32'hA000_0004, 32'hA000_0003, 6, 1, 0));
    step_b("b_pop1", 0, POP, 0, 0, mk(M_ALL, 32'hA000_0004, 32'hA000_0003, 32'hA000_0002, 5, 1, 0));
    step_b("b_pop2", 0, POP, 0, 0, mk(M_ALL, 32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 4, 1, 0));
    step_b("b_rst_push", 1, PUSH, 32'h1234_5678, 0, mk(M_TN, 0, 0, 0, 0, 0, 0));
    step_b("b_after",    0, PUSH, 32'hFFFF_0001, 0, mk(M_T, 32'hFFFF_0001, 0, 0, 1, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
